periph_bus_arbiter: RTL and testbench

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_periph_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// ============================================================================
// Module   : periph_bus_arbiter
// Purpose  : Two-master to single-peripheral bus arbiter with a 4-state FSM.
//            Define ARB_FIXED_PRIO_EN for fixed m0 priority (default: round-robin).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_bus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] p_read_address,
  input  logic [31:0] p_read_data,
  output logic [31:0] p_write_address,
  output logic [31:0] p_write_data,
  output logic        p_write_enable,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDATA  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_cmd_we;
  logic [31:0] r_cmd_addr;
  logic [31:0] r_cmd_wdata;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        w_any_req;
  logic        w_winner;
  logic        w_accept;

  assign w_any_req = m0_req | m1_req;
  assign w_accept  = (r_state == ST_IDLE) && w_any_req;

`ifdef ARB_FIXED_PRIO_EN
  // m0 wins whenever it is requesting; m1 only when m0 is idle
  assign w_winner = ~m0_req;
`else
  logic r_last_owner;

  always_comb begin
    w_winner = m1_req;
    if (m0_req && m1_req) begin
      w_winner = ~r_last_owner;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= 1'b1;
    end else if (w_accept) begin
      r_last_owner <= w_winner;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= 32'd0;
      r_cmd_wdata <= 32'd0;
      r_m0_rdata  <= 32'd0;
      r_m1_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner     <= w_winner;
        r_cmd_we    <= w_winner ? m1_we    : m0_we;
        r_cmd_addr  <= w_winner ? m1_addr  : m0_addr;
        r_cmd_wdata <= w_winner ? m1_wdata : m0_wdata;
      end
      // Peripheral data is valid one cycle after the address was presented
      if (r_state == ST_RDATA) begin
        if (r_owner) begin
          r_m1_rdata <= p_read_data;
        end else begin
          r_m0_rdata <= p_read_data;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = r_cmd_we ? ST_IDLE : ST_RDATA;
      ST_RDATA:  w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Peripheral buses come straight from the command registers so they hold in IDLE
  assign p_read_address  = r_cmd_addr;
  assign p_write_address = r_cmd_addr;
  assign p_write_data    = r_cmd_wdata;
  assign p_write_enable  = (r_state == ST_ACCESS) && r_cmd_we;
  assign busy            = (r_state != ST_IDLE);

  assign m0_gnt    = (r_state == ST_ACCESS) && !r_owner;
  assign m1_gnt    = (r_state == ST_ACCESS) &&  r_owner;
  assign m0_rvalid = (r_state == ST_RESP)   && !r_owner;
  assign m1_rvalid = (r_state == ST_RESP)   &&  r_owner;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
// ============================================================================
// Module   : tb_periph_bus_arbiter
// Purpose  : Self-checking bench for periph_bus_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] p_read_address, p_read_data, p_write_address, p_write_data;
  logic        p_write_enable, busy;

  periph_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .p_read_address(p_read_address), .p_read_data(p_read_data),
    .p_write_address(p_write_address), .p_write_data(p_write_data),
    .p_write_enable(p_write_enable), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral: registered read with a fixed address-to-data mapping
  function automatic logic [31:0] periph(input logic [31:0] a);
    if (a == 32'hA000_0000) return 32'h1234_5678;
    return a ^ 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) p_read_data <= periph(p_read_address);

  typedef struct {
    bit          rd;
    bit          m;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t sb[$];

  typedef struct {
    bit          m;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every write strobe and rvalid must match the queue head
  always @(negedge clk) begin
    ev_t e;
    if (p_write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: addr %h data %h expected none", p_write_address, p_write_data);
      end else begin
        e = sb.pop_front();
        chk("wr_kind", 32'(e.rd), 32'd0);
        chk("wr_addr", p_write_address, e.addr);
        chk("wr_data", p_write_data, e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rvalid: m0 %b m1 %b expected none", m0_rvalid, m1_rvalid);
      end else begin
        e = sb.pop_front();
        chk("rd_kind", 32'(e.rd), 32'd1);
        chk("rd_master", 32'(m1_rvalid), 32'(e.m));
        chk("rd_both", 32'(m0_rvalid & m1_rvalid), 32'd0);
        chk("rd_data", e.m ? m1_rdata : m0_rdata, e.data);
        chk("rd_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input bit m, input bit req, input bit we,
                       input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    end
  endtask

  // Called at a negedge with the DUT in IDLE
  task automatic do_txn(input bit m, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    int t0;
    int k;
    logic [31:0] other;
    t0    = cyc;
    other = m ? m0_rdata : m1_rdata;
    sb.push_back('{rd: !we, m: m, addr: a, data: (we ? d : exp_rd), cyc: (we ? t0 + 1 : t0 + 3)});
    drive(m, 1'b1, we, a, d);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(m ? m1_gnt : m0_gnt) && k < 20);
    chk("gnt_latency", k, 1);
    chk("non_owner_gnt", 32'(m ? m0_gnt : m1_gnt), 32'd0);
    drive(m, 1'b0, we, a, d);
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("busy_cycles", k, we ? 1 : 3);
    chk("other_rdata", m ? m0_rdata : m1_rdata, other);
    if (!we) chk("rdata_hold", m ? m1_rdata : m0_rdata, exp_rd);
    chk("p_addr_idle_hold", p_write_address, a);
    chk("p_we_idle", 32'(p_write_enable), 32'd0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_m1;
    int t0;

    vt[0] = '{m: 1'b0, we: 1'b1, addr: 32'hA000_0001, wdata: 32'h0000_03FF, exp_rd: 32'h0};
    vt[1] = '{m: 1'b1, we: 1'b0, addr: 32'hA000_0000, wdata: 32'h0,         exp_rd: 32'h1234_5678};
    vt[2] = '{m: 1'b0, we: 1'b1, addr: 32'h0000_0010, wdata: 32'hCAFE_F00D, exp_rd: 32'h0};
    vt[3] = '{m: 1'b0, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,         exp_rd: 32'hDEAD_BEFF};
    vt[4] = '{m: 1'b1, we: 1'b1, addr: 32'hFFFF_FFFF, wdata: 32'hFFFF_FFFF, exp_rd: 32'h0};
    vt[5] = '{m: 1'b1, we: 1'b0, addr: 32'hFFFF_FFFF, wdata: 32'h0,         exp_rd: 32'h2152_4110};
    vt[6] = '{m: 1'b0, we: 1'b0, addr: 32'h0000_0000, wdata: 32'h0,         exp_rd: 32'hDEAD_BEEF};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, p_write_enable}), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_p_addr", p_write_address, 32'd0);
    chk("rst_p_rdaddr", p_read_address, 32'd0);
    chk("rst_p_wdata", p_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back transactions, including a write right after a read completes
    for (int i = 0; i < 7; i++) begin
      do_txn(vt[i].m, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
    end

    // Contention: both masters write continuously from a fresh reset
    pulse_reset();
    t0 = cyc;
    for (int j = 0; j < 4; j++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_m1 = 1'b0;
`else
      exp_m1 = (j % 2) == 1;
`endif
      sb.push_back('{rd: 1'b0, m: exp_m1, addr: (exp_m1 ? 32'h0000_0200 : 32'h0000_0100),
                     data: (exp_m1 ? 32'h0000_00BB : 32'h0000_00AA), cyc: t0 + 1 + 2 * j});
    end
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_00AA);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_00BB);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((i % 2) == 0) begin
`ifdef ARB_FIXED_PRIO_EN
        exp_m1 = 1'b0;
`else
        exp_m1 = ((i / 2) % 2) == 1;
`endif
        chk("cont_m0_gnt", 32'(m0_gnt), 32'(!exp_m1));
        chk("cont_m1_gnt", 32'(m1_gnt), 32'(exp_m1));
      end
      if (i == 6) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("cont_idle", 32'(busy), 32'd0);

    // Reset asserted while an m0 read sits in RDATA
    t0 = cyc;
    sb.push_back('{rd: 1'b1, m: 1'b0, addr: 32'hA000_0000, data: 32'h1234_5678, cyc: t0 + 3});
    drive(1'b0, 1'b1, 1'b0, 32'hA000_0000, 32'h0);
    @(negedge clk);
    chk("rr_gnt", 32'(m0_gnt), 32'd1);
    m0_req = 1'b0;
    @(negedge clk);
    chk("rr_busy_rdata", 32'(busy), 32'd1);
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("rr_busy_now", 32'(busy), 32'd0);
    chk("rr_outs_now", 32'({m0_gnt, m0_rvalid, m1_rvalid, p_write_enable}), 32'd0);
    chk("rr_p_addr_now", p_read_address, 32'd0);
    chk("rr_m0_rdata_now", m0_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rr_no_rvalid", 32'(m0_rdata), 32'd0);
    do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEFF);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
